// File: rtl/add_pkg.sv
// Shared types and helpers for the digit-serial adder family.
package add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, used to size the digit counter.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/add_digit.sv
// Combinational DIGIT-bit ripple-carry slice built from full adders.
// Also exposes the carry into the top bit so callers can derive signed overflow.
module add_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] carry;

    // Ripple the carry through one full adder per bit.
    always_comb begin
        carry    = '0;
        s        = '0;
        carry[0] = ci;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]       = x[i] ^ y[i] ^ carry[i];
            carry[i+1] = (x[i] & y[i]) | (x[i] & carry[i]) | (y[i] & carry[i]);
        end
    end

    assign co    = carry[DIGIT];
    assign c_msb = carry[DIGIT-1];

endmodule

// File: rtl/add_serial.sv
// Digit-serial adder: one DIGIT-bit slice is reused over WIDTH/DIGIT cycles,
// with valid/ready handshakes on the operand and result sides.
module add_serial
    import add_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (clog2(NDIG) < 1) ? 1 : clog2(NDIG);
    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [DIGIT-1:0] d_s;
    logic             d_co;
    logic             d_c_msb;
    logic [WIDTH-1:0] sum_next;
    logic             last_digit;

    add_digit #(.DIGIT(DIGIT)) u_slice (
        .x     (a_sh[DIGIT-1:0]),
        .y     (b_sh[DIGIT-1:0]),
        .ci    (carry),
        .s     (d_s),
        .co    (d_co),
        .c_msb (d_c_msb)
    );

    // Each new digit enters at the top so the sum is LSB-aligned after NDIG steps.
    generate
        if (NDIG == 1) begin : g_single
            assign sum_next = d_s;
        end else begin : g_multi
            assign sum_next = {d_s, sum[WIDTH-1:DIGIT]};
        end
    endgenerate

    assign last_digit = (cnt == LAST_DIG);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshakes; DONE can hand over directly to a new operation.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (last_digit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    accept     = in_valid;
                    state_next = in_valid ? BUSY : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand shifting, carry chaining and result capture; results only move in BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= c_in;
            cnt   <= '0;
        end else if (state == BUSY) begin
            sum   <= sum_next;
            a_sh  <= a_sh >> DIGIT;
            b_sh  <= b_sh >> DIGIT;
            carry <= d_co;
            cnt   <= cnt + CNT_W'(1);
            if (last_digit) begin
                c_out <= d_co;
                ovf   <= d_c_msb ^ d_co;
            end
        end
    end

endmodule
